uart_mmio_bridge: RTL and testbench

- Memory-mapped register front end for the full-duplex UART block, placed between the RISC-V core's data-memory port and the UART.
- Converts CPU stores into single-cycle send pulses toward the UART's transmit FIFO.
- Buffers received bytes and their error flags in a small local RX queue that the CPU pops by load.
- Holds the parity and baud configuration, sticky status flags, and an interrupt output.

---
 rtl/uart_mmio_bridge.sv | 145 ++++++++++++++
 tb/tb_uart_mmio_bridge.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_mmio_bridge.sv
// Memory-mapped register front end between the CPU data port and the UART block.
// Stores to TXDATA become one-cycle send pulses; received bytes wait in a small queue popped by loads.
module uart_mmio_bridge #(
   parameter int RX_DEPTH = 4,
   parameter int RX_AW    = 2
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic [3:0]  mem_addr,
   input  logic        mem_we,
   input  logic        mem_re,
   input  logic [31:0] mem_wdata,
   output logic [31:0] mem_rdata,
   output logic        mem_rvalid,
   output logic        uart_send,
   output logic [7:0]  uart_data_in,
   output logic [1:0]  uart_parity_type,
   output logic [1:0]  uart_baud_rate,
   input  logic        uart_tx_fifo_full,
   input  logic        uart_tx_fifo_empty,
   input  logic        uart_tx_active,
   input  logic        uart_rx_done,
   input  logic [7:0]  uart_rx_data,
   input  logic [2:0]  uart_error_flag,
   output logic        irq
);
   localparam logic [1:0] REG_TXDATA = 2'd0;
   localparam logic [1:0] REG_RXDATA = 2'd1;
   localparam logic [1:0] REG_STATUS = 2'd2;
   localparam logic [1:0] REG_CTRL   = 2'd3;

   logic             send_q, send_d;
   logic [7:0]       data_in_q, data_in_d;
   logic [5:0]       ctrl_q, ctrl_d;
   logic             rx_overrun_q, rx_overrun_d;
   logic             tx_overflow_q, tx_overflow_d;
   logic             rx_error_q, rx_error_d;
   logic             rx_done_prev_q;
   logic [RX_AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [RX_AW:0]   count_q, count_d;
   logic [31:0]      rdata_q, rdata_d;
   logic             rvalid_q, irq_q, irq_d;
   logic [10:0]      rx_mem [RX_DEPTH];

   logic [1:0]  sel;
   logic        wr_en, rd_en, push, pop, push_ok, rx_avail, rx_full;
   logic        tx_accept, tx_drop, overrun_set;
   logic [31:0] status;
   logic        unused_bits;

   assign sel         = mem_addr[3:2];
   assign wr_en       = mem_we;
   // A store in the same cycle wins; the load is dropped entirely.
   assign rd_en       = mem_re & ~mem_we;
   assign rx_avail    = (count_q != '0);
   assign rx_full     = (count_q == (RX_AW+1)'(RX_DEPTH));
   assign push        = uart_rx_done & ~rx_done_prev_q;
   assign pop         = rd_en && (sel == REG_RXDATA) && rx_avail;
   assign push_ok     = push && (!rx_full || pop);
   assign overrun_set = push && rx_full && !pop;
   assign tx_accept   = wr_en && (sel == REG_TXDATA) && !uart_tx_fifo_full;
   assign tx_drop     = wr_en && (sel == REG_TXDATA) && uart_tx_fifo_full;
   assign count_d     = count_q + (RX_AW+1)'(push_ok) - (RX_AW+1)'(pop);
   assign unused_bits = ^{mem_addr[1:0], mem_wdata[31:8]};

   assign status = {24'b0, rx_error_q, tx_overflow_q, rx_overrun_q, rx_full, rx_avail,
                    uart_tx_active, uart_tx_fifo_empty, uart_tx_fifo_full};

   always_comb begin
      send_d        = tx_accept;
      data_in_d     = tx_accept ? mem_wdata[7:0] : data_in_q;
      ctrl_d        = (wr_en && sel == REG_CTRL) ? mem_wdata[5:0] : ctrl_q;
      rx_overrun_d  = rx_overrun_q;
      tx_overflow_d = tx_overflow_q;
      rx_error_d    = rx_error_q;
      if (wr_en && sel == REG_STATUS) begin
         if (mem_wdata[5]) rx_overrun_d  = 1'b0;
         if (mem_wdata[6]) tx_overflow_d = 1'b0;
         if (mem_wdata[7]) rx_error_d    = 1'b0;
      end
      // Set events are applied last so they win over a same-cycle clear.
      if (overrun_set)                   rx_overrun_d  = 1'b1;
      if (tx_drop)                       tx_overflow_d = 1'b1;
      if (push && uart_error_flag != '0) rx_error_d    = 1'b1;
   end

   always_comb begin
      rdata_d = rdata_q;
      if (rd_en) begin
         case (sel)
            REG_RXDATA: rdata_d = rx_avail ? {1'b1, 20'b0, rx_mem[rd_ptr_q]} : 32'b0;
            REG_STATUS: rdata_d = status;
            REG_CTRL:   rdata_d = {26'b0, ctrl_q};
            default:    rdata_d = 32'b0;
         endcase
      end
   end

   assign irq_d = (ctrl_q[4] & rx_avail) | (ctrl_q[5] & uart_tx_fifo_empty & ~uart_tx_active)
                | rx_overrun_q | rx_error_q;

   always_ff @(posedge clock) begin
      if (push_ok) rx_mem[wr_ptr_q] <= {uart_error_flag, uart_rx_data};
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         send_q         <= 1'b0;
         data_in_q      <= '0;
         ctrl_q         <= '0;
         rx_overrun_q   <= 1'b0;
         tx_overflow_q  <= 1'b0;
         rx_error_q     <= 1'b0;
         rx_done_prev_q <= 1'b0;
         wr_ptr_q       <= '0;
         rd_ptr_q       <= '0;
         count_q        <= '0;
         rdata_q        <= '0;
         rvalid_q       <= 1'b0;
         irq_q          <= 1'b0;
      end else begin
         send_q         <= send_d;
         data_in_q      <= data_in_d;
         ctrl_q         <= ctrl_d;
         rx_overrun_q   <= rx_overrun_d;
         tx_overflow_q  <= tx_overflow_d;
         rx_error_q     <= rx_error_d;
         rx_done_prev_q <= uart_rx_done;
         if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q        <= count_d;
         rdata_q        <= rdata_d;
         rvalid_q       <= rd_en;
         irq_q          <= irq_d;
      end
   end

   assign mem_rdata        = rdata_q;
   assign mem_rvalid       = rvalid_q;
   assign uart_send        = send_q;
   assign uart_data_in     = data_in_q;
   assign uart_parity_type = ctrl_q[1:0];
   assign uart_baud_rate   = ctrl_q[3:2];
   assign irq              = irq_q;
endmodule

// File: tb/tb_uart_mmio_bridge.sv
// Scoreboard bench for uart_mmio_bridge: a queue-based reference model predicts every load
// result and transmit pulse; independent monitors pop and compare what the bridge produces.
module tb_uart_mmio_bridge;
   localparam int DEPTH = 4;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic [3:0]  mem_addr = '0;
   logic        mem_we = 1'b0;
   logic        mem_re = 1'b0;
   logic [31:0] mem_wdata = '0;
   logic [31:0] mem_rdata;
   logic        mem_rvalid;
   logic        uart_send;
   logic [7:0]  uart_data_in;
   logic [1:0]  uart_parity_type;
   logic [1:0]  uart_baud_rate;
   logic        uart_tx_fifo_full = 1'b0;
   logic        uart_tx_fifo_empty = 1'b0;
   logic        uart_tx_active = 1'b0;
   logic        uart_rx_done = 1'b0;
   logic [7:0]  uart_rx_data = '0;
   logic [2:0]  uart_error_flag = '0;
   logic        irq;

   uart_mmio_bridge #(.RX_DEPTH(DEPTH), .RX_AW(2)) dut (
      .clock(clock), .reset_n(reset_n), .mem_addr(mem_addr), .mem_we(mem_we),
      .mem_re(mem_re), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
      .uart_send(uart_send), .uart_data_in(uart_data_in), .uart_parity_type(uart_parity_type),
      .uart_baud_rate(uart_baud_rate), .uart_tx_fifo_full(uart_tx_fifo_full),
      .uart_tx_fifo_empty(uart_tx_fifo_empty), .uart_tx_active(uart_tx_active),
      .uart_rx_done(uart_rx_done), .uart_rx_data(uart_rx_data),
      .uart_error_flag(uart_error_flag), .irq(irq)
   );

   always #5 clock = ~clock;

   int total = 0;
   int bad = 0;

   // Reference model state
   int unsigned rxq[$];
   logic [31:0] rd_exp[$];
   logic [7:0]  tx_exp[$];
   logic        m_ovr, m_ovf, m_err, m_prev_done, m_irq;
   logic [5:0]  m_ctrl;
   logic [7:0]  m_last_tx;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      rxq.delete();
      rd_exp.delete();
      tx_exp.delete();
      m_ovr = 0; m_ovf = 0; m_err = 0; m_prev_done = 0; m_irq = 0;
      m_ctrl = '0; m_last_tx = '0;
   endtask

   // Read scoreboard and transmit scoreboard
   always @(negedge clock) begin
      if (reset_n) begin
         if (mem_rvalid) begin
            if (rd_exp.size() == 0) check("unexpected_rvalid", {31'b0, mem_rvalid}, 32'd0);
            else begin
               logic [31:0] e;
               e = rd_exp.pop_front();
               check("rdata", mem_rdata, e);
               $display("load  rdata=%h expected=%h", mem_rdata, e);
            end
         end
         if (uart_send) begin
            if (tx_exp.size() == 0) check("unexpected_send", {31'b0, uart_send}, 32'd0);
            else begin
               logic [7:0] t;
               t = tx_exp.pop_front();
               check("tx_data", {24'b0, uart_data_in}, {24'b0, t});
               $display("send  data=%h expected=%h", uart_data_in, t);
            end
         end
      end
   end

   // Applies the current inputs to the model, advances one clock, checks the steady outputs.
   task automatic step();
      logic [1:0]  sel;
      logic [31:0] st;
      int          pre;
      logic        popped;
      sel = mem_addr[3:2];
      pre = rxq.size();
      popped = 0;
      m_irq = (m_ctrl[4] && pre != 0) || (m_ctrl[5] && uart_tx_fifo_empty && !uart_tx_active)
              || m_ovr || m_err;
      st = {24'b0, m_err, m_ovf, m_ovr, pre == DEPTH, pre != 0,
            uart_tx_active, uart_tx_fifo_empty, uart_tx_fifo_full};
      if (mem_re && !mem_we) begin
         case (sel)
            2'd0: rd_exp.push_back(32'd0);
            2'd1: begin
               if (pre > 0) begin
                  rd_exp.push_back(32'h8000_0000 | rxq.pop_front());
                  popped = 1;
               end else rd_exp.push_back(32'd0);
            end
            2'd2: rd_exp.push_back(st);
            default: rd_exp.push_back({26'b0, m_ctrl});
         endcase
      end
      if (mem_we && sel == 2'd2) begin
         if (mem_wdata[5]) m_ovr = 0;
         if (mem_wdata[6]) m_ovf = 0;
         if (mem_wdata[7]) m_err = 0;
      end
      if (mem_we && sel == 2'd0) begin
         if (!uart_tx_fifo_full) begin
            tx_exp.push_back(mem_wdata[7:0]);
            m_last_tx = mem_wdata[7:0];
         end else m_ovf = 1;
      end
      if (mem_we && sel == 2'd3) m_ctrl = mem_wdata[5:0];
      if (uart_rx_done && !m_prev_done) begin
         if (uart_error_flag != 0) m_err = 1;
         if (pre < DEPTH || popped) rxq.push_back({21'b0, uart_error_flag, uart_rx_data});
         else m_ovr = 1;
      end
      m_prev_done = uart_rx_done;
      @(posedge clock);
      #1;
      mem_we = 0;
      mem_re = 0;
      check("irq", {31'b0, irq}, {31'b0, m_irq});
      check("parity", {30'b0, uart_parity_type}, {30'b0, m_ctrl[1:0]});
      check("baud", {30'b0, uart_baud_rate}, {30'b0, m_ctrl[3:2]});
      check("tx_hold", {24'b0, uart_data_in}, {24'b0, m_last_tx});
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic wr(input logic [3:0] a, input logic [31:0] d);
      mem_addr = a; mem_wdata = d; mem_we = 1;
      step();
   endtask

   task automatic rd(input logic [3:0] a);
      mem_addr = a; mem_re = 1;
      step();
   endtask

   task automatic rx_byte(input logic [2:0] e, input logic [7:0] d, input int hold);
      uart_rx_done = 1; uart_rx_data = d; uart_error_flag = e;
      idle(hold);
      uart_rx_done = 0;
      step();
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_send"}, {31'b0, uart_send}, 32'd0);
      check({tag, "_data_in"}, {24'b0, uart_data_in}, 32'd0);
      check({tag, "_rdata"}, mem_rdata, 32'd0);
      check({tag, "_rvalid"}, {31'b0, mem_rvalid}, 32'd0);
      check({tag, "_ctrl"}, {28'b0, uart_baud_rate, uart_parity_type}, 32'd0);
      check({tag, "_irq"}, {31'b0, irq}, 32'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      model_reset();
      repeat (3) @(posedge clock);
      #1;
      check_reset_outputs("reset");
      @(negedge clock);
      reset_n = 1;
      @(posedge clock);
      #1;

      // CTRL write and readback
      wr(4'hC, 32'h0000_0035);
      rd(4'hC);
      check("parity_01", {30'b0, uart_parity_type}, 32'd1);
      check("baud_01", {30'b0, uart_baud_rate}, 32'd1);
      idle(1);

      // TX accept, TX drop on full, sticky clear
      wr(4'h0, 32'h0000_0041);
      idle(2);
      uart_tx_fifo_full = 1;
      wr(4'h0, 32'h0000_0099);
      uart_tx_fifo_full = 0;
      rd(4'h8);
      wr(4'h8, 32'h0000_0040);
      rd(4'h8);
      idle(1);

      // Held rx_done pushes once
      rx_byte(3'b000, 8'h5A, 3);
      rd(4'h4);
      rd(4'h4);
      idle(1);

      // Overrun with five pushes, then drain across pointer wrap
      for (int i = 1; i <= 5; i++) rx_byte(3'b000, 8'(i), 1);
      rd(4'h8);
      idle(1);
      check("irq_after_overrun", {31'b0, irq}, 32'd1);
      for (int i = 0; i < 4; i++) rd(4'h4);
      wr(4'h8, 32'h0000_00E0);
      idle(1);

      // Pop and push in the same cycle with the queue full
      for (int i = 0; i < 4; i++) rx_byte(3'b000, 8'(8'h10 + i), 1);
      uart_rx_done = 1; uart_rx_data = 8'h77; uart_error_flag = 0;
      mem_addr = 4'h4; mem_re = 1;
      step();
      uart_rx_done = 0;
      step();
      rd(4'h8);
      for (int i = 0; i < 4; i++) rd(4'h4);
      idle(1);

      // Error flag capture
      rx_byte(3'b100, 8'h33, 1);
      rd(4'h4);
      rd(4'h8);
      idle(2);

      // Reset mid-stream, just after a send pulse
      rx_byte(3'b000, 8'hA1, 1);
      rx_byte(3'b000, 8'hA2, 1);
      idle(2);
      wr(4'h0, 32'h0000_0055);
      #1;
      reset_n = 0;
      #1;
      check_reset_outputs("midreset");
      model_reset();
      @(negedge clock);
      reset_n = 1;
      @(posedge clock);
      #1;
      rd(4'h8);
      rd(4'h4);
      idle(1);

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         mem_we = ($urandom_range(0, 7) == 0);
         mem_re = ($urandom_range(0, 3) == 0);
         mem_addr = 4'($urandom_range(0, 15));
         mem_wdata = $urandom();
         uart_tx_fifo_full = ($urandom_range(0, 3) == 0);
         uart_tx_fifo_empty = 1'($urandom_range(0, 1));
         uart_tx_active = 1'($urandom_range(0, 1));
         uart_rx_done = ($urandom_range(0, 2) == 0);
         uart_rx_data = 8'($urandom());
         uart_error_flag = ($urandom_range(0, 3) == 0) ? 3'($urandom()) : 3'b000;
         step();
      end
      uart_rx_done = 0;
      idle(3);

      check("rd_scoreboard_drained", rd_exp.size(), 32'd0);
      check("tx_scoreboard_drained", tx_exp.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
